// File: rtl/cnnip_pkg.sv
// cnnip_pkg: shared sizing constants and byte-address to word-index helper
//   CNNIP_MEM_DEPTH : default number of stored words
//   CNNIP_ADDR_W    : default byte-address width
//   CNNIP_DATA_W    : default data width
//   word_idx()      : byte address -> word index, wrapped modulo depth
package cnnip_pkg;
   localparam int CNNIP_MEM_DEPTH = 256;
   localparam int CNNIP_ADDR_W    = 10;
   localparam int CNNIP_DATA_W    = 32;
   function automatic int unsigned word_idx(input logic [31:0] addr, input int unsigned depth);
      return (addr >> 2) % depth;
   endfunction
endpackage

// File: rtl/cnnip_mem_if.sv
// cnnip_mem_if: controller-side single-port memory interface
//   en/we/addr/din : request from controller (master -> slave)
//   dout           : read data back to controller (slave -> master)
interface cnnip_mem_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) ();
   logic              en;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] din;
   logic [DATA_W-1:0] dout;
   modport slave  (input en, we, addr, din, output dout);
   modport master (output en, we, addr, din, input dout);
endinterface

// File: rtl/cnnip_spram_core.sv
// cnnip_spram_core: single-port write-first RAM, read latency 1, contents never reset
//   clk   : rising-edge clock
//   en/we : access enable / write enable
//   idx   : word index
//   wdata : write data
//   rdata : registered read data
module cnnip_spram_core #(
   parameter int DEPTH  = 256,
   parameter int DATA_W = 32,
   parameter int IDX_W  = 8
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [IDX_W-1:0]  idx,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem_q[idx] <= wdata;
            rdata_q    <= wdata;
         end else begin
            rdata_q    <= mem_q[idx];
         end
      end
   end
   assign rdata = rdata_q;
endmodule

// File: rtl/cnnip_mem_responder.sv
// cnnip_mem_responder: shared word memory with controller-priority arbitration, host return pipe and status
//   clk_a / arstz_aq          : clock, async active-low reset
//   to_ctrlr                  : controller memory port (always wins the array)
//   host_valid/ready/we/addr/wdata : host request channel, ready = !to_ctrlr.en
//   host_rdata / host_rvalid  : host read return
//   err_misaligned            : sticky flag for any access with addr[1:0] != 0
//   ctl_wr_cnt                : saturating count of controller writes
//   stat_clr                  : sync clear of status, wins over set/increment
//   Macro CNNIP_MEM_OUTREG_EN : adds an output register, read latency 2 on both ports
module cnnip_mem_responder
   import cnnip_pkg::*;
#(
   parameter int DEPTH  = CNNIP_MEM_DEPTH,
   parameter int ADDR_W = CNNIP_ADDR_W,
   parameter int DATA_W = CNNIP_DATA_W
) (
   input  logic              clk_a,
   input  logic              arstz_aq,
   cnnip_mem_if.slave        to_ctrlr,
   input  logic              host_valid,
   output logic              host_ready,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic [DATA_W-1:0] host_rdata,
   output logic              host_rvalid,
   output logic              err_misaligned,
   output logic [15:0]       ctl_wr_cnt,
   input  logic              stat_clr
);
   localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
`ifdef CNNIP_MEM_OUTREG_EN
   localparam int RV_W = 2;
`else
   localparam int RV_W = 1;
`endif
   logic              host_acc, host_rd, mem_en, mem_we, misaligned;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata, core_rdata, dout, dout_d, dout_q, hrdata_d, hrdata_q;
   logic              ctl_rd_q, err_d, err_q;
   logic [RV_W-1:0]   hrd_d, hrd_q;
   logic [15:0]       cnt_d, cnt_q;
   always_comb begin
      host_ready = !to_ctrlr.en;
      host_acc   = host_valid & !to_ctrlr.en;
      host_rd    = host_acc & !host_we;
      mem_en     = to_ctrlr.en | host_acc;
      mem_we     = to_ctrlr.en ? to_ctrlr.we   : host_we;
      mem_addr   = to_ctrlr.en ? to_ctrlr.addr : host_addr;
      mem_wdata  = to_ctrlr.en ? to_ctrlr.din  : host_wdata;
      misaligned = mem_en & (|mem_addr[1:0]);
      err_d      = stat_clr ? 1'b0 : err_q | misaligned;
      cnt_d      = stat_clr ? 16'd0 : (to_ctrlr.en & to_ctrlr.we & (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
      // the shared array output belongs to whichever port read on the previous edge
      dout_d     = ctl_rd_q ? core_rdata : dout_q;
      hrdata_d   = hrd_q[0] ? core_rdata : hrdata_q;
`ifdef CNNIP_MEM_OUTREG_EN
      hrd_d       = {hrd_q[0], host_rd};
      dout        = dout_q;
      host_rdata  = hrdata_q;
      host_rvalid = hrd_q[1];
`else
      hrd_d       = host_rd;
      dout        = dout_d;
      host_rdata  = hrdata_d;
      host_rvalid = hrd_q[0];
`endif
   end
   always_ff @(posedge clk_a or negedge arstz_aq) begin
      if (!arstz_aq) begin
         ctl_rd_q <= 1'b0;
         hrd_q    <= '0;
         dout_q   <= '0;
         hrdata_q <= '0;
         err_q    <= 1'b0;
         cnt_q    <= 16'd0;
      end else begin
         ctl_rd_q <= to_ctrlr.en & !to_ctrlr.we;
         hrd_q    <= hrd_d;
         dout_q   <= dout_d;
         hrdata_q <= hrdata_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   end
   cnnip_spram_core #(.DEPTH(DEPTH), .DATA_W(DATA_W), .IDX_W(IDX_W)) u_core (
      .clk   (clk_a),
      .en    (mem_en),
      .we    (mem_we),
      .idx   (IDX_W'(word_idx(32'(mem_addr), DEPTH))),
      .wdata (mem_wdata),
      .rdata (core_rdata)
   );
   assign to_ctrlr.dout  = dout;
   assign err_misaligned = err_q;
   assign ctl_wr_cnt     = cnt_q;
endmodule
